// File: rtl/mvau_ctrl_pkg.sv
// mvau_ctrl_pkg: shared state type and width helper for the MVAU stream controller
package mvau_ctrl_pkg;
  typedef enum logic {S_FILL, S_REUSE} ctrl_state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvau_wrap_counter.sv
// mvau_wrap_counter: enabled modulo-MAX counter with a wrap strobe for chaining
module mvau_wrap_counter import mvau_ctrl_pkg::*; #(
  parameter int MAX = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en & (cnt == W'(MAX - 1));
  // Advance on enable, returning to zero after MAX-1
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/mvau_stream_ctrl_hs.sv
// mvau_stream_ctrl_hs: handshaked SF x NF x NUM_VEC sequencer for the MVAU input buffer and accumulator
module mvau_stream_ctrl_hs import mvau_ctrl_pkg::*; #(
  parameter int SF = 8,
  parameter int NF = 2,
  parameter int NUM_VEC = 4,
  parameter int SF_T = clog2_min1(SF),
  parameter int NF_T = clog2_min1(NF),
  parameter int VEC_T = clog2_min1(NUM_VEC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic            wt_v,
  output logic            wt_rdy,
  output logic            out_v,
  input  logic            out_rdy,
  output logic            out_last,
  output logic            ib_wen,
  output logic            ib_ren,
  output logic [SF_T-1:0] ib_addr,
  output logic            mac_en,
  output logic            sf_clr,
  output logic            sf_last
);
  ctrl_state_t      state;
  logic [SF_T-1:0]  sf_cnt;
  logic [NF_T-1:0]  nf_cnt;
  logic [VEC_T-1:0] vec_cnt;
  logic             fill, stall, fire, sf_wrap, nf_wrap, vec_wrap_unused;
  assign fill    = state == S_FILL;
  assign stall   = out_v & ~out_rdy;
  assign fire    = wt_v & ~stall & (fill ? in_v : 1'b1);
  assign in_rdy  = fill & wt_v & ~stall;
  assign wt_rdy  = fire;
  assign mac_en  = fire;
  assign ib_wen  = fill & fire;
  assign ib_ren  = ~fill & fire;
  assign ib_addr = sf_cnt;
  assign sf_clr  = fire & (sf_cnt == '0);
  assign sf_last = sf_wrap;
  mvau_wrap_counter #(.MAX(SF), .W(SF_T)) u_sf (
    .clk(clk), .rst_n(rst_n), .en(fire), .cnt(sf_cnt), .wrap(sf_wrap)
  );
  mvau_wrap_counter #(.MAX(NF), .W(NF_T)) u_nf (
    .clk(clk), .rst_n(rst_n), .en(sf_wrap), .cnt(nf_cnt), .wrap(nf_wrap)
  );
  mvau_wrap_counter #(.MAX(NUM_VEC), .W(VEC_T)) u_vec (
    .clk(clk), .rst_n(rst_n), .en(nf_wrap), .cnt(vec_cnt), .wrap(vec_wrap_unused)
  );
  // Buffer is filled on the first neuron fold and replayed for the rest; with NF==1 nf_wrap keeps it in S_FILL
  always_ff @(posedge clk)
    if (!rst_n) state <= S_FILL;
    else if (sf_wrap) state <= nf_wrap ? S_FILL : S_REUSE;
  // Column result becomes valid after its last chunk and is held until downstream takes it
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_v    <= 1'b0;
      out_last <= 1'b0;
    end else if (sf_last) begin
      out_v    <= 1'b1;
      out_last <= (nf_cnt == NF_T'(NF - 1)) & (vec_cnt == VEC_T'(NUM_VEC - 1));
    end else if (out_rdy) begin
      out_v    <= 1'b0;
    end
endmodule

// File: tb/tb_mvau_stream_ctrl_hs.sv
// tb_mvau_stream_ctrl_hs: directed and random checks of two controller configurations against a chunk-index model
module tb_mvau_stream_ctrl_hs;
  logic clk = 1'b0;
  logic rst_n, in_v, wt_v, out_rdy;
  logic a_in_rdy, a_wt_rdy, a_out_v, a_out_last, a_ib_wen, a_ib_ren, a_mac_en, a_sf_clr, a_sf_last;
  logic b_in_rdy, b_wt_rdy, b_out_v, b_out_last, b_ib_wen, b_ib_ren, b_mac_en, b_sf_clr, b_sf_last;
  logic [1:0] a_ib_addr;
  logic [0:0] b_ib_addr;
  logic [11:0] o[2];
  int checks = 0, errors = 0, ovcnt = 0;
  int k[2];
  bit mov[2], mol[2];
  bit armed = 0;

  always #5 clk = ~clk;

  mvau_stream_ctrl_hs #(.SF(4), .NF(2), .NUM_VEC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(a_in_rdy), .wt_v(wt_v), .wt_rdy(a_wt_rdy),
    .out_v(a_out_v), .out_rdy(out_rdy), .out_last(a_out_last), .ib_wen(a_ib_wen), .ib_ren(a_ib_ren),
    .ib_addr(a_ib_addr), .mac_en(a_mac_en), .sf_clr(a_sf_clr), .sf_last(a_sf_last)
  );
  mvau_stream_ctrl_hs #(.SF(1), .NF(1), .NUM_VEC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(b_in_rdy), .wt_v(wt_v), .wt_rdy(b_wt_rdy),
    .out_v(b_out_v), .out_rdy(out_rdy), .out_last(b_out_last), .ib_wen(b_ib_wen), .ib_ren(b_ib_ren),
    .ib_addr(b_ib_addr), .mac_en(b_mac_en), .sf_clr(b_sf_clr), .sf_last(b_sf_last)
  );

  assign o[0] = {a_in_rdy, a_wt_rdy, a_out_v, a_out_last, a_ib_wen, a_ib_ren, a_mac_en, a_sf_clr, a_sf_last, 1'b0, a_ib_addr};
  assign o[1] = {b_in_rdy, b_wt_rdy, b_out_v, b_out_last, b_ib_wen, b_ib_ren, b_mac_en, b_sf_clr, b_sf_last, 2'b00, b_ib_addr};

  function automatic int psf(input int d); return d == 0 ? 4 : 1; endfunction
  function automatic int pnf(input int d); return d == 0 ? 2 : 1; endfunction
  function automatic int pnv(input int d); return d == 0 ? 2 : 1; endfunction

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL d%0d_%s observed=%0h expected=%0h", d, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the chunk-index model, then advance the model
  task automatic step(input logic r, input logic iv, input logic wv, input logic ordy);
    int sf, nf, vec;
    bit fl, st, fi;
    int nk[2];
    bit nov[2], nol[2];
    rst_n = r; in_v = iv; wt_v = wv; out_rdy = ordy;
    #1;
    if (o[0][9] === 1'b1) ovcnt++;
    for (int d = 0; d < 2; d++) begin
      sf  = k[d] % psf(d);
      nf  = (k[d] / psf(d)) % pnf(d);
      vec = k[d] / (psf(d) * pnf(d));
      fl  = nf == 0;
      st  = mov[d] && !ordy;
      fi  = wv && !st && (fl ? iv : 1'b1);
      if (armed) begin
        chk(d, "in_rdy",  32'(o[d][11]), 32'(fl && wv && !st));
        chk(d, "wt_rdy",  32'(o[d][10]), 32'(fi));
        chk(d, "out_v",   32'(o[d][9]),  32'(mov[d]));
        if (mov[d]) chk(d, "out_last", 32'(o[d][8]), 32'(mol[d]));
        chk(d, "ib_wen",  32'(o[d][7]),  32'(fl && fi));
        chk(d, "ib_ren",  32'(o[d][6]),  32'(!fl && fi));
        chk(d, "mac_en",  32'(o[d][5]),  32'(fi));
        chk(d, "sf_clr",  32'(o[d][4]),  32'(fi && sf == 0));
        chk(d, "sf_last", 32'(o[d][3]),  32'(fi && sf == psf(d) - 1));
        chk(d, "ib_addr", 32'(o[d][2:0]), sf);
      end
      nk[d] = k[d]; nov[d] = mov[d]; nol[d] = mol[d];
      if (!r) begin
        nk[d] = 0; nov[d] = 0; nol[d] = 0;
      end else begin
        if (fi && sf == psf(d) - 1) begin
          nov[d] = 1;
          nol[d] = (nf == pnf(d) - 1) && (vec == pnv(d) - 1);
        end else if (ordy) nov[d] = 0;
        if (fi) nk[d] = (k[d] + 1) % (psf(d) * pnf(d) * pnv(d));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      k[d] = nk[d]; mov[d] = nov[d]; mol[d] = nol[d];
    end
    if (!r) armed = 1;
    @(negedge clk);
  endtask

  task automatic run_to_out_v();
    int n = 0;
    while (!mov[0] && n < 40) begin
      step(1, 1, 1, 1);
      n++;
    end
    chk(0, "reach_out_v", 32'(a_out_v), 1);
  endtask

  initial begin
    rst_n = 0; in_v = 0; wt_v = 0; out_rdy = 1;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    chk(0, "rst_out_last", 32'(a_out_last), 0);
    chk(1, "rst_out_last", 32'(b_out_last), 0);
    repeat (34) step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    repeat (3) step(1, 0, 1, 1);
    chk(0, "gap_addr", 32'(a_ib_addr), 2);
    chk(0, "gap_in_rdy", 32'(a_in_rdy), 1);
    repeat (6) step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    run_to_out_v();
    repeat (5) step(1, 1, 1, 0);
    chk(0, "bp_held_out_v", 32'(a_out_v), 1);
    repeat (8) step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    run_to_out_v();
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    chk(0, "mid_addr", 32'(a_ib_addr), 2);
    chk(0, "mid_ren", 32'(a_ib_ren), 1);
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    run_to_out_v();
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    chk(0, "post_rst_out_v", 32'(a_out_v), 0);
    chk(0, "post_rst_clr", 32'(a_sf_clr), 1);
    chk(0, "post_rst_wen", 32'(a_ib_wen), 1);
    step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    ovcnt = 0;
    for (int i = 0; i < 32; i++) step(1, 1, (i % 2) == 0, 1);
    repeat (2) step(1, 1, 0, 1);
    chk(0, "toggle_out_v_count", ovcnt, 4);
    repeat (400)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
